// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score renderer.
//   GLYPH_W / GLYPH_H : digit cell size in unscaled pixels
//   bcd_t             : one decimal digit (codes 10..15 draw blank)
//   BLANK_DIGIT       : code substituted for a digit that must not be drawn
//   cvt_state_e       : double-dabble converter states
//   pow10()           : 10^n, used for the saturation constant
package score_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 16;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK_DIGIT = 4'd10;

  // CAP is a one-cycle hold between capture and the first shift, so busy
  // rises the cycle after a load is accepted.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAP   = 2'd1,
    ST_SHIFT = 2'd2
  } cvt_state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational digit bitmap source, 16x16 cells.
//   digit : BCD code, 10..15 give a blank glyph
//   line  : glyph line 0..15 (0,1,14,15 always blank)
//   row   : 16 pixel bits, bit 15 is the leftmost column
// Glyphs are seven-segment shapes: horizontal bars span columns 1..14,
// vertical bars are two columns wide at columns 1-2 and 13-14.
module glyph_rom
  import score_pkg::*;
(
  input  bcd_t                digit,
  input  logic [3:0]          line,
  output logic [GLYPH_W-1:0]  row
);

  localparam logic [GLYPH_W-1:0] BAR_H = 16'h7FFE;
  localparam logic [GLYPH_W-1:0] BAR_L = 16'h6000;
  localparam logic [GLYPH_W-1:0] BAR_R = 16'h0006;

  logic [6:0] seg;  // {a,b,c,d,e,f,g}
  logic       upper, lower;

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  always_comb begin
    row   = '0;
    upper = (line >= 4'd2) && (line <= 4'd7);
    lower = (line >= 4'd8) && (line <= 4'd13);
    if ((line == 4'd2  || line == 4'd3)  && seg[6]) row = row | BAR_H;  // a
    if ((line == 4'd7  || line == 4'd8)  && seg[0]) row = row | BAR_H;  // g
    if ((line == 4'd12 || line == 4'd13) && seg[3]) row = row | BAR_H;  // d
    if (upper && seg[1]) row = row | BAR_L;  // f
    if (upper && seg[5]) row = row | BAR_R;  // b
    if (lower && seg[2]) row = row | BAR_L;  // e
    if (lower && seg[4]) row = row | BAR_R;  // c
  end

endmodule

// File: rtl/score_display.sv
// score_display: binary score -> BCD (sequential double-dabble), latched at
// frame start, rendered as a row of scaled 16x16 digit glyphs.
//   clk, rst_n        : pixel clock, async active-low reset
//   score/score_load  : value and single-cycle convert request
//   frame_start       : copies pending BCD to the shown BCD
//   pix_x/pix_y/pix_valid : current raster position
//   busy              : conversion in progress
//   pix_on/pix_on_valid   : glyph pixel, 2 cycles after the raster inputs
// Build option: LEAD_ZERO_BLANK_EN blanks leading zeros of the shown value.
module score_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 16,
  parameter int Y0         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_load,
  input  logic               frame_start,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic               pix_valid,
  output logic               busy,
  output logic               pix_on,
  output logic               pix_on_valid
);

  localparam int          BCD_W   = NUM_DIGITS * 4;
  localparam int          CNT_W   = $clog2(SCORE_W + 1);
  localparam int          FIELD_W = NUM_DIGITS * (GLYPH_W << SCALE_LOG2);
  localparam int          FIELD_H = GLYPH_H << SCALE_LOG2;
  localparam int unsigned SAT_LIM = pow10(NUM_DIGITS);
  localparam int          STAGES  = 2;

  // ---------------- converter ----------------
  cvt_state_e               state_q, state_nxt;
  logic [SCORE_W-1:0]       bin_q, start_val, sat_val;
  bcd_t [NUM_DIGITS-1:0]    acc_q, acc_adj, pend_q, shown_q;
  logic [BCD_W-1:0]         adj_flat, acc_sh;
  logic [CNT_W-1:0]         cnt_q;
  logic                     q_vld;
  logic [SCORE_W-1:0]       q_val;
  logic                     last, start;

  assign last = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(SCORE_W - 1));

  // While shifting, loads queue; on the final shift a same-cycle load is
  // newer than the queued value, so it wins.
  assign start     = ((state_q != ST_SHIFT) && score_load) ||
                     (last && (score_load || q_vld));
  assign start_val = ((state_q == ST_SHIFT) && !score_load) ? q_val : score;
  assign sat_val   = (32'(start_val) >= SAT_LIM) ? SCORE_W'(SAT_LIM - 1)
                                                 : start_val;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (acc_q[i] >= 4'd5) acc_adj[i] = acc_q[i] + 4'd3;
  end

  assign adj_flat = acc_adj;
  assign acc_sh   = {adj_flat[BCD_W-2:0], bin_q[SCORE_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (score_load) state_nxt = ST_CAP;
      ST_CAP:   state_nxt = score_load ? ST_CAP : ST_SHIFT;
      ST_SHIFT: if (last) state_nxt = start ? ST_CAP : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      q_vld   <= 1'b0;
      q_val   <= '0;
      pend_q  <= '0;
      shown_q <= '0;
    end else begin
      if (start) begin
        bin_q <= sat_val;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == ST_SHIFT) begin
        bin_q <= bin_q << 1;
        acc_q <= acc_sh;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last) begin
        q_vld <= 1'b0;
      end else if ((state_q == ST_SHIFT) && score_load) begin
        q_vld <= 1'b1;
        q_val <= score;
      end
      if (last) pend_q <= acc_sh;
      // A conversion finishing on the frame edge is already the newest value.
      if (frame_start) shown_q <= last ? acc_sh : pend_q;
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [10:0] px, py, dx, dy;
  logic        in_f;
  logic        s1_in;
  logic [2:0]  s1_slot;
  logic [3:0]  s1_col, s1_line;
  logic [STAGES:1] vld_pipe;

  assign px   = {1'b0, pix_x};
  assign py   = {1'b0, pix_y};
  assign dx   = px - 11'(X0);
  assign dy   = py - 11'(Y0);
  assign in_f = (px >= 11'(X0)) && (dx < 11'(FIELD_W)) &&
                (py >= 11'(Y0)) && (dy < 11'(FIELD_H));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_in    <= 1'b0;
      s1_slot  <= '0;
      s1_col   <= '0;
      s1_line  <= '0;
      vld_pipe <= '0;
    end else begin
      s1_in    <= in_f;
      s1_slot  <= 3'(dx >> (4 + SCALE_LOG2));
      s1_col   <= 4'(dx >> SCALE_LOG2);
      s1_line  <= 4'(dy >> SCALE_LOG2);
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
    end
  end

  bcd_t [NUM_DIGITS-1:0] disp;
  bcd_t                  cur_dig;
  logic [GLYPH_W-1:0]    glyph_row;

`ifdef LEAD_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    disp = shown_q;
    lead = 1'b1;
    // The least significant digit is always drawn.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && (shown_q[i] == 4'd0)) disp[i] = BLANK_DIGIT;
      else                              lead    = 1'b0;
    end
  end
`else
  assign disp = shown_q;
`endif

  // Slot 0 is leftmost and carries the most significant digit.
  always_comb begin
    cur_dig = BLANK_DIGIT;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s1_slot == 3'(NUM_DIGITS - 1 - i)) cur_dig = disp[i];
  end

  glyph_rom u_glyph_rom (
    .digit (cur_dig),
    .line  (s1_line),
    .row   (glyph_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_on <= 1'b0;
    else        pix_on <= s1_in & vld_pipe[1] & glyph_row[~s1_col];
  end

  assign pix_on_valid = vld_pipe[STAGES];

endmodule

// File: doc/score_display.md
# score_display

Parametrised on-screen score renderer for the VGA pipeline. It converts a binary score to BCD with a sequential double-dabble engine, latches the result only at frame start so the image never tears, and produces a 1-bit pixel-on signal for a row of 16×16 digit glyphs at a configurable origin and integer power-of-two scale. It sits between the game-state logic and the colour mux, alongside the other sprite pixel generators.

## Interface
Parameters:
- NUM_DIGITS, 4: number of displayed decimal digits (1–6).
- SCORE_W, 14: binary score width.
- SCALE_LOG2, 1: glyph magnification is 2^SCALE_LOG2 in both axes (0–3).
- X0, 16: left pixel column of the score field.
- Y0, 16: top pixel row of the score field.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- score  in  SCORE_W  binary score value, sampled on an accepted load.
- score_load  in  1  single-cycle request to convert `score`.
- frame_start  in  1  single-cycle pulse at the start of vertical blank.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- pix_valid  in  1  pix_x/pix_y are inside the active area.
- busy  out  1  conversion in progress.
- pix_on  out  1  the current pixel belongs to a lit glyph bit.
- pix_on_valid  out  1  pix_valid delayed to align with pix_on.

## Operation
- Reset values: busy=0, pix_on=0, pix_on_valid=0. Pending and shown BCD registers are all zero, so the field displays zeros. Any queued load is dropped.
- Load acceptance:
  - A load with busy=0 captures `score` and starts a conversion.
  - A load with busy=1 is written into a one-deep queue. A later load overwrites the queued value, so the newest value wins.
  - When a conversion finishes and the queue holds a value, the next conversion starts on the following cycle.
- Saturation: if the captured score is ≥ 10^NUM_DIGITS, it is replaced at capture by 10^NUM_DIGITS−1, so every digit shows 9. Conversion timing is unchanged.
- Conversion: double-dabble, one shift per cycle, SCORE_W iterations. Each BCD nibble that is ≥5 gets +3 before the shift. On completion the result is written to the pending register.
- Frame latch:
  - On frame_start, the pending register is copied to the shown register.
  - If a conversion completes in the same cycle as frame_start, the newly completed value is the one latched.
  - The shown register changes at no other time.
- Pixel mapping:
  - dx = pix_x − X0, dy = pix_y − Y0.
  - The pixel is inside the field when 0 ≤ dx < NUM_DIGITS·(16<<SCALE_LOG2) and 0 ≤ dy < (16<<SCALE_LOG2).
  - Digit slot = dx >> (4+SCALE_LOG2). Slot 0 is leftmost and shows the most significant digit.
  - col = (dx >> SCALE_LOG2) & 15; line = (dy >> SCALE_LOG2) & 15.
  - Glyph row bit 15 is the leftmost column, so the selected bit is row[15−col].
  - pix_on = inside & pix_valid & selected bit.
- Glyphs: 16 lines per digit. Lines 0, 1, 14 and 15 are blank. Digit codes 10–15 produce a blank glyph.

## Timing
- Conversion latency: accept at edge t. busy=1 from t+1 through t+SCORE_W. The pending register is updated at edge t+SCORE_W+1, and busy falls in the same cycle.
- A queued load raises busy again one cycle after busy falls.
- Pixel pipeline: 2 stages.
  - Stage 1 registers inside, slot, col, line and pix_valid.
  - Stage 2 registers the glyph bit.
  - pix_on and pix_on_valid appear 2 cycles after their pix_x/pix_y/pix_valid inputs.
- The pixel pipeline runs every cycle regardless of conversion state.
- Reset asserted mid-conversion aborts immediately. All state returns to reset values asynchronously.

## Configuration
- LEAD_ZERO_BLANK_EN defined:
  - Leading zero digits are blanked (code 10 substituted) from the most significant digit down to the first non-zero digit.
  - The least significant digit is never blanked, so 0 shows as a single "0" in the rightmost slot.
  - Blanking is computed from the shown register.
- LEAD_ZERO_BLANK_EN undefined: all NUM_DIGITS digits are always drawn, with leading zeros.

## Structure
- Package score_pkg holds:
  - GLYPH_W=16 and GLYPH_H=16.
  - typedef bcd_t (logic [3:0]).
  - BLANK_DIGIT=4'd10.
  - A function computing 10^n for the saturation constant.
- Sub-module glyph_rom: combinational, (bcd_t digit, 4-bit line) → 16-bit row. It is the single source of the digit bitmaps and is instantiated once, in pixel stage 2.

## Test plan
- Reset and idle: release rst_n, scan the field with SCALE_LOG2=1 -> all four slots draw "0000" (LEAD_ZERO_BLANK_EN off); pix_on is never asserted outside the field.
- Conversion and latch: load 1234, wait 15 cycles -> busy high for exactly 14 cycles; display still "0000" until frame_start, then "1234".
- Overrun queue: load 5, then load 77 and 900 while busy -> 5 converts, then 900 converts; 77 is never shown; busy stays low for exactly one cycle between the conversions.
- Saturation: load 12000 with NUM_DIGITS=4 -> after frame_start the field shows "9999".
- Pixel alignment: set pix_x=X0+2, pix_y=Y0+4 with digit 0 shown -> pix_on=1 and pix_on_valid=1 exactly 2 cycles later; pix_x=X0+0 gives pix_on=0.
- Leading-zero blanking (LEAD_ZERO_BLANK_EN on): show 42 -> slots 0–1 are blank and slots 2–3 show "42"; show 0 -> only slot 3 shows "0".
